// File: rtl/fp_io_pkg.sv
// Shared definitions for the floating-point adder board I/O front end:
// operand widths, entry-stage encoding and the default debounce interval.
package fp_io_pkg;

  localparam int FP_W             = 32;
  localparam int HALF_W           = 16;
  localparam int DEBOUNCE_DEFAULT = 500000;

  typedef enum logic [1:0] {
    STG_A_LO = 2'd0,
    STG_A_HI = 2'd1,
    STG_B_LO = 2'd2,
    STG_B_HI = 2'd3
  } stage_e;

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: two-flop synchroniser, stable-interval debounce counter and
// a single-cycle press pulse on the released->pressed transition.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press_pulse
);

  logic             key_sync_p0;
  logic             key_sync_p1;
  logic             db_pressed;
  logic [CNT_W-1:0] cnt;
  logic             raw_pressed;

  // Stage p0/p1: raw key synchronisation; reset to the released (high) level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_sync_p0 <= 1'b1;
      key_sync_p1 <= 1'b1;
    end else begin
      key_sync_p0 <= key_n;
      key_sync_p1 <= key_sync_p0;
    end
  end

  assign raw_pressed = ~key_sync_p1;

  // Debounce: the level must disagree for DEBOUNCE_CYCLES consecutive cycles to flip
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_pressed  <= 1'b0;
      cnt         <= '0;
      press_pulse <= 1'b0;
    end else begin
      press_pulse <= 1'b0;
      if (raw_pressed == db_pressed) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        db_pressed  <= raw_pressed;
        cnt         <= '0;
        press_pulse <= raw_pressed;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_operand_loader.sv
// Operand entry front end: debounced enter/cancel keys walk four half-word
// entries and commit A and B together so the adder never sees a partial operand.
module fp_operand_loader
  import fp_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] SW,
  input  logic [1:0]  KEY,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic        operands_valid,
  output logic [1:0]  stage,
  output logic [15:0] display_word
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic              enter_pulse;
  logic              cancel_pulse;
  stage_e            stage_q;
  logic [FP_W-1:0]   a_sh;
  logic [HALF_W-1:0] b_sh;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_enter (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_n      (KEY[0]),
    .press_pulse(enter_pulse)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_cancel (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_n      (KEY[1]),
    .press_pulse(cancel_pulse)
  );

  // Entry FSM: cancel takes priority over a coincident enter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q        <= STG_A_LO;
      a_sh           <= '0;
      b_sh           <= '0;
      a              <= '0;
      b              <= '0;
      operands_valid <= 1'b0;
      display_word   <= '0;
    end else begin
      operands_valid <= 1'b0;
      display_word   <= SW;
      if (cancel_pulse) begin
        stage_q <= STG_A_LO;
        a_sh    <= '0;
        b_sh    <= '0;
      end else if (enter_pulse) begin
        case (stage_q)
          STG_A_LO: begin
            a_sh[HALF_W-1:0] <= SW;
            stage_q          <= STG_A_HI;
          end
          STG_A_HI: begin
            a_sh[FP_W-1:HALF_W] <= SW;
            stage_q             <= STG_B_LO;
          end
          STG_B_LO: begin
            b_sh    <= SW;
            stage_q <= STG_B_HI;
          end
          default: begin
            a              <= a_sh;
            b              <= {SW, b_sh};
            operands_valid <= 1'b1;
            stage_q        <= STG_A_LO;
          end
        endcase
      end
    end
  end

  assign stage = stage_q;

endmodule

// File: tb/tb_fp_operand_loader.sv
// Scenario bench for fp_operand_loader with a short debounce interval; commits
// are predicted into a queue and checked by a monitor as operands_valid fires.
module tb_fp_operand_loader;

  logic        clk;
  logic        rst_n;
  logic [15:0] SW;
  logic [1:0]  KEY;
  logic [31:0] a;
  logic [31:0] b;
  logic        operands_valid;
  logic [1:0]  stage;
  logic [15:0] display_word;

  int total;
  int bad;
  int valid_cnt;

  logic [63:0] sb_q[$];
  logic [1:0]  exp_stage;
  logic [31:0] exp_a;
  logic [31:0] exp_b;
  logic [31:0] exp_a_sh;
  logic [15:0] exp_b_lo;

  fp_operand_loader #(.DEBOUNCE_CYCLES(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .SW            (SW),
    .KEY           (KEY),
    .a             (a),
    .b             (b),
    .operands_valid(operands_valid),
    .stage         (stage),
    .display_word  (display_word)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Commit monitor: every valid pulse must match the oldest predicted commit
  always @(negedge clk) begin
    if (rst_n && operands_valid) begin
      valid_cnt = valid_cnt + 1;
      total = total + 1;
      if (sb_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL commit_unexpected: a=%h b=%h with no commit predicted", a, b);
      end else begin
        logic [63:0] exp_ab;
        exp_ab = sb_q.pop_front();
        if ({a, b} !== exp_ab) begin
          bad = bad + 1;
          $display("FAIL commit_value: a=%h b=%h expected a=%h b=%h",
                   a, b, exp_ab[63:32], exp_ab[31:0]);
        end
      end
    end
  end

  task automatic model_reset();
    exp_stage = 2'd0;
    exp_a     = '0;
    exp_b     = '0;
    exp_a_sh  = '0;
    exp_b_lo  = '0;
    sb_q.delete();
  endtask

  task automatic enter_word(input logic [15:0] sw, input int hold);
    @(negedge clk);
    SW = sw;
    case (exp_stage)
      2'd0: exp_a_sh[15:0]  = sw;
      2'd1: exp_a_sh[31:16] = sw;
      2'd2: exp_b_lo        = sw;
      default: begin
        exp_a = exp_a_sh;
        exp_b = {sw, exp_b_lo};
        sb_q.push_back({exp_a, exp_b});
      end
    endcase
    exp_stage = exp_stage + 2'd1;
    KEY[0] = 1'b0;
    repeat (hold) @(negedge clk);
    KEY[0] = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic press_cancel();
    @(negedge clk);
    KEY[1] = 1'b0;
    repeat (12) @(negedge clk);
    KEY[1] = 1'b1;
    repeat (12) @(negedge clk);
    exp_stage = 2'd0;
    exp_a_sh  = '0;
    exp_b_lo  = '0;
  endtask

  task automatic test_reset();
    total = total + 1;
    if ({a, b, operands_valid, stage, display_word} !== 83'd0) begin
      bad = bad + 1;
      $display("FAIL reset_state: a=%h b=%h v=%b stage=%0d disp=%h, expected all zero",
               a, b, operands_valid, stage, display_word);
    end
    enter_word(16'h1234, 12);
    enter_word(16'h5678, 12);
    total = total + 1;
    if (stage !== 2'd2) begin
      bad = bad + 1;
      $display("FAIL reset_pre_stage: stage=%0d expected 2", stage);
    end
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    total = total + 1;
    if (a !== 32'd0 || b !== 32'd0 || stage !== 2'd0 || operands_valid !== 1'b0) begin
      bad = bad + 1;
      $display("FAIL reset_async: a=%h b=%h stage=%0d v=%b expected zeros", a, b, stage, operands_valid);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full_entry();
    int v0;
    v0 = valid_cnt;
    enter_word(16'h0000, 12);
    enter_word(16'h3F80, 12);
    enter_word(16'h0000, 12);
    total = total + 1;
    if (valid_cnt != v0) begin
      bad = bad + 1;
      $display("FAIL full_early_valid: pulses=%0d expected 0 before fourth word", valid_cnt - v0);
    end
    enter_word(16'h4000, 12);
    total = total + 1;
    if (a !== 32'h3F800000 || b !== 32'h40000000) begin
      bad = bad + 1;
      $display("FAIL full_operands: a=%h b=%h expected 3f800000 40000000", a, b);
    end
    total = total + 1;
    if (valid_cnt - v0 != 1 || stage !== 2'd0) begin
      bad = bad + 1;
      $display("FAIL full_pulse_stage: pulses=%0d stage=%0d expected 1 and 0", valid_cnt - v0, stage);
    end
  endtask

  task automatic test_display();
    @(negedge clk);
    SW = 16'hA5C3;
    @(negedge clk);
    total = total + 1;
    if (display_word !== 16'hA5C3) begin
      bad = bad + 1;
      $display("FAIL display_word: got %h expected a5c3", display_word);
    end
  endtask

  task automatic test_bounce();
    int v0;
    v0 = valid_cnt;
    @(negedge clk);
    SW = 16'hBEEF;
    KEY[0] = 1'b0;
    repeat (3) @(negedge clk);
    KEY[0] = 1'b1;
    repeat (12) @(negedge clk);
    total = total + 1;
    if (stage !== exp_stage) begin
      bad = bad + 1;
      $display("FAIL bounce_short: stage=%0d expected %0d", stage, exp_stage);
    end
    enter_word(16'h1111, 100);
    total = total + 1;
    if (stage !== exp_stage || valid_cnt != v0) begin
      bad = bad + 1;
      $display("FAIL bounce_hold: stage=%0d pulses=%0d expected stage %0d pulses 0",
               stage, valid_cnt - v0, exp_stage);
    end
  endtask

  task automatic test_cancel();
    int v0;
    v0 = valid_cnt;
    enter_word(16'h2222, 12);
    total = total + 1;
    if (stage !== 2'd2) begin
      bad = bad + 1;
      $display("FAIL cancel_pre_stage: stage=%0d expected 2", stage);
    end
    press_cancel();
    total = total + 1;
    if (stage !== 2'd0 || a !== exp_a || b !== exp_b || valid_cnt != v0) begin
      bad = bad + 1;
      $display("FAIL cancel: stage=%0d a=%h b=%h pulses=%0d expected 0 %h %h 0",
               stage, a, b, valid_cnt - v0, exp_a, exp_b);
    end
  endtask

  task automatic test_simultaneous();
    int v0;
    enter_word(16'h3333, 12);
    enter_word(16'h4444, 12);
    v0 = valid_cnt;
    @(negedge clk);
    SW = 16'h5555;
    KEY = 2'b00;
    repeat (12) @(negedge clk);
    KEY = 2'b11;
    repeat (12) @(negedge clk);
    exp_stage = 2'd0;
    exp_a_sh  = '0;
    exp_b_lo  = '0;
    total = total + 1;
    if (stage !== 2'd0 || a !== exp_a || b !== exp_b || valid_cnt != v0) begin
      bad = bad + 1;
      $display("FAIL simultaneous: stage=%0d a=%h b=%h pulses=%0d expected 0 %h %h 0",
               stage, a, b, valid_cnt - v0, exp_a, exp_b);
    end
  endtask

  task automatic test_stability();
    logic [31:0] a_prev;
    logic [31:0] b_prev;
    logic [15:0] words [4];
    words[0] = 16'hC0DE;
    words[1] = 16'h4120;
    words[2] = 16'h0001;
    words[3] = 16'hC2C8;
    enter_word(16'hAAAA, 12);
    enter_word(16'hBBBB, 12);
    enter_word(16'hCCCC, 12);
    enter_word(16'hDDDD, 12);
    a_prev = a;
    b_prev = b;
    for (int i = 0; i < 3; i++) begin
      enter_word(words[i], 12);
      total = total + 1;
      if (a !== a_prev || b !== b_prev || stage !== exp_stage) begin
        bad = bad + 1;
        $display("FAIL stability_%0d: a=%h b=%h stage=%0d expected %h %h %0d",
                 i, a, b, stage, a_prev, b_prev, exp_stage);
      end
    end
    enter_word(words[3], 12);
    total = total + 1;
    if (a !== 32'h4120C0DE || b !== 32'hC2C80001) begin
      bad = bad + 1;
      $display("FAIL stability_commit: a=%h b=%h expected 4120c0de c2c80001", a, b);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    valid_cnt = 0;
    model_reset();
    SW    = 16'h0000;
    KEY   = 2'b11;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    test_reset();
    test_full_entry();
    test_display();
    test_bounce();
    test_cancel();
    test_simultaneous();
    test_stability();

    repeat (4) @(negedge clk);
    total = total + 1;
    if (sb_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL scoreboard_drain: %0d predicted commits never seen, expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1);
  end

endmodule
